spu_wb_pipe: RTL and testbench
==============================

# spu_wb_pipe

Per-pipe result staging and writeback block for the SPU-Lite processor, one instance each for the even and odd pipes. It accepts results from that pipe's execution units and shifts them through a fixed-depth staging register. It delivers results to the register file's rt write port at a common final stage. It also provides operand forwarding and hazard (pending) lookup to the operand-fetch logic for results still in flight.

## Interface
- DEPTH, 7, number of staging stages; also the writeback stage index (legal 2..8)
- DATA_WD, 128, result width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  new result issued to the pipe this cycle
- in_rt_addr  in  7  destination register
- in_data  in  DATA_WD  result value (assumed valid at issue; see lat)
- in_lat  in  4  unit latency: stage at which the result becomes forwardable
- flush  in  1  kill all in-flight entries
- fwd_addr_a / fwd_addr_b / fwd_addr_c  in  7 each  operand addresses to look up
- fwd_hit_a / _b / _c  out  1 each  a ready in-flight result matches
- fwd_data_a / _b / _c  out  DATA_WD each  forwarded value (0 when no hit)
- fwd_pend_a / _b / _c  out  1 each  the youngest match is not yet ready (stall)
- wb_en  out  1  drives rt_wr_en_ep/op
- wb_addr  out  7  drives rt_addr_ep/op
- wb_data  out  DATA_WD  drives rt_wr_ep/op
- occupancy  out  $clog2(DEPTH+1)  count of valid entries

## Operation
- Stage k (1..DEPTH) holds valid, rt_addr, data, and lat.
- Every cycle, each stage shifts to k+1 unconditionally. There is no backpressure.
- Stage 1 loads the input when in_valid=1; otherwise stage 1 becomes invalid.
- lat is clamped on capture: 0 becomes 1, and values above DEPTH become DEPTH.
- An entry is ready when k >= lat.
- Writeback: wb_en/wb_addr/wb_data come directly from the stage DEPTH registers, with no combinational path from the inputs.
  - When wb_en=0, wb_addr and wb_data are 0.
- Forward lookup (combinational, three independent ports): among valid entries with rt_addr == fwd_addr_x, select the lowest k (youngest).
  - If the selected entry is ready: hit=1, data = entry data, pend=0.
  - If it is not ready: hit=0, pend=1, data=0.
  - If there is no match: all outputs are 0.
  - An older ready entry never masks a younger unready entry.
- The input being presented in the current cycle is not visible to the lookup.
- Flush: on the edge where flush=1, all stages become invalid and a concurrent in_valid is dropped.
  - During the flush cycle itself, outputs still reflect the pre-flush contents.
- Register 0 is not special; all 128 addresses are forwarded and written.
- occupancy is the count of valid stages, computed from the registers.

## Timing
- Reset (synchronous): all stages invalid, with data, addr, and lat cleared.
  - wb_en=0, wb_addr=0, wb_data=0, all fwd_* = 0, occupancy=0 on the cycle after rst is sampled.
- Reset mid-operation discards every entry. No writeback occurs for them.
- If a result is presented in cycle t:
  - It occupies stage k during cycle t+k.
  - wb_en is high during cycle t+DEPTH.
  - The register file is updated at the end of cycle t+DEPTH.
  - From cycle t+DEPTH+1 the value is readable from the register file.
- Forwarding window: hit during cycles t+lat .. t+DEPTH; pend during cycles t+1 .. t+lat-1.
- Throughput: one result per cycle, sustained indefinitely. The pipe holds at most DEPTH entries and cannot overflow.
- Same address in flight twice: the younger entry governs forwarding. Both entries write back in order, so the younger one's value lands last.
- flush and rst together: rst dominates, with the same resulting state.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1 and fwd_addr_a=5 -> all outputs are 0 and occupancy=0 on the cycle after the first sampled rst edge.
- Single result, DEPTH=7: addr 5, data 0xA5..A5, lat 2 in cycle 0.
  - fwd_pend_a=1 in cycle 1.
  - fwd_hit_a=1 with data 0xA5..A5 in cycles 2..7.
  - wb_en=1, wb_addr=5 in cycle 7 only.
- Youngest wins: addr 9 with data 0x1 (lat 1) in cycle 0, then addr 9 with data 0x2 (lat 4) in cycle 1.
  - In cycles 2..4: pend=1, hit=0.
  - In cycle 5: hit, data 0x2.
  - Writebacks: 0x1 in cycle 7, 0x2 in cycle 8.
- Back-to-back stream: 10 consecutive results, addr 0..9.
  - occupancy saturates at 7.
  - wb_en stays high for cycles 7..16 with addresses in order.
- Flush: 3 entries in flight, flush=1 together with in_valid in cycle 4 -> cycle 5 occupancy=0; no wb_en ever issued for those 4 results.
- lat clamp: lat=0 -> hit in cycle 1; lat=15 -> pend in cycles 1..6 and hit in cycle 7 only.

Source files
------------

// File: rtl/spu_wb_pipe_if.sv
// Result-issue, forwarding-lookup and writeback signals of one SPU-Lite pipe.
// master = issue/operand-fetch side, slave = spu_wb_pipe.
interface spu_wb_pipe_if #(
  parameter int DEPTH   = 7,
  parameter int DATA_WD = 128
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic               in_valid;
  logic [6:0]         in_rt_addr;
  logic [DATA_WD-1:0] in_data;
  logic [3:0]         in_lat;
  logic               flush;

  logic [6:0]         fwd_addr_a, fwd_addr_b, fwd_addr_c;
  logic               fwd_hit_a,  fwd_hit_b,  fwd_hit_c;
  logic [DATA_WD-1:0] fwd_data_a, fwd_data_b, fwd_data_c;
  logic               fwd_pend_a, fwd_pend_b, fwd_pend_c;

  logic               wb_en;
  logic [6:0]         wb_addr;
  logic [DATA_WD-1:0] wb_data;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output in_valid, in_rt_addr, in_data, in_lat, flush,
    output fwd_addr_a, fwd_addr_b, fwd_addr_c,
    input  fwd_hit_a, fwd_hit_b, fwd_hit_c,
    input  fwd_data_a, fwd_data_b, fwd_data_c,
    input  fwd_pend_a, fwd_pend_b, fwd_pend_c,
    input  wb_en, wb_addr, wb_data, occupancy
  );

  modport slave (
    input  in_valid, in_rt_addr, in_data, in_lat, flush,
    input  fwd_addr_a, fwd_addr_b, fwd_addr_c,
    output fwd_hit_a, fwd_hit_b, fwd_hit_c,
    output fwd_data_a, fwd_data_b, fwd_data_c,
    output fwd_pend_a, fwd_pend_b, fwd_pend_c,
    output wb_en, wb_addr, wb_data, occupancy
  );
endinterface

// File: rtl/spu_wb_pipe.sv
// Per-pipe result staging shift register with rt writeback at the last stage,
// plus three independent youngest-match forwarding/pending lookup ports.

module spu_wb_fwd_port #(
  parameter int DEPTH   = 7,
  parameter int DATA_WD = 128
) (
  input  logic [DEPTH:1]              vld,
  input  logic [DEPTH:1][6:0]         addr,
  input  logic [DEPTH:1][DATA_WD-1:0] data,
  input  logic [DEPTH:1][3:0]         lat,
  input  logic [6:0]                  fwd_addr,
  output logic                        hit,
  output logic                        pend,
  output logic [DATA_WD-1:0]          dout
);
  // Scan oldest to youngest so the lowest matching stage has the final say;
  // an older ready copy can never hide a younger unready one.
  always_comb begin
    hit  = 1'b0;
    pend = 1'b0;
    dout = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (vld[k] && addr[k] == fwd_addr) begin
        if (k >= int'(lat[k])) begin
          hit  = 1'b1;
          pend = 1'b0;
          dout = data[k];
        end else begin
          hit  = 1'b0;
          pend = 1'b1;
          dout = '0;
        end
      end
    end
  end
endmodule

module spu_wb_pipe #(
  parameter int DEPTH   = 7,
  parameter int DATA_WD = 128
) (
  input  logic          clk,
  input  logic          rst,
  spu_wb_pipe_if.slave  bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH:1]              vld_pipe;
  logic [DEPTH:1][6:0]         addr_pipe;
  logic [DEPTH:1][DATA_WD-1:0] data_pipe;
  logic [DEPTH:1][3:0]         lat_pipe;
  logic [3:0]                  lat_clamp;
  logic [OCC_W-1:0]            occ;

  always_comb begin
    lat_clamp = bus.in_lat;
    if (bus.in_lat == 4'd0)
      lat_clamp = 4'd1;
    else if (bus.in_lat > 4'(DEPTH))
      lat_clamp = 4'(DEPTH);
  end

  // Empty slots carry all-zero payload, so the writeback port is zero when idle.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
      data_pipe <= '0;
      lat_pipe  <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[DEPTH-1:1], bus.in_valid};
      addr_pipe <= {addr_pipe[DEPTH-1:1], bus.in_valid ? bus.in_rt_addr : 7'd0};
      data_pipe <= {data_pipe[DEPTH-1:1], bus.in_valid ? bus.in_data : {DATA_WD{1'b0}}};
      lat_pipe  <= {lat_pipe[DEPTH-1:1], bus.in_valid ? lat_clamp : 4'd0};
    end
  end

  assign bus.wb_en   = vld_pipe[DEPTH];
  assign bus.wb_addr = vld_pipe[DEPTH] ? addr_pipe[DEPTH] : 7'd0;
  assign bus.wb_data = vld_pipe[DEPTH] ? data_pipe[DEPTH] : {DATA_WD{1'b0}};

  always_comb begin
    occ = '0;
    for (int k = 1; k <= DEPTH; k++)
      occ = occ + OCC_W'(vld_pipe[k]);
  end
  assign bus.occupancy = occ;

  logic [2:0][6:0]         fwd_addr_v;
  logic [2:0]              hit_v, pend_v;
  logic [2:0][DATA_WD-1:0] data_v;

  assign fwd_addr_v = {bus.fwd_addr_c, bus.fwd_addr_b, bus.fwd_addr_a};

  for (genvar p = 0; p < 3; p++) begin : g_fwd
    spu_wb_fwd_port #(.DEPTH(DEPTH), .DATA_WD(DATA_WD)) u_port (
      .vld      (vld_pipe),
      .addr     (addr_pipe),
      .data     (data_pipe),
      .lat      (lat_pipe),
      .fwd_addr (fwd_addr_v[p]),
      .hit      (hit_v[p]),
      .pend     (pend_v[p]),
      .dout     (data_v[p])
    );
  end

  assign bus.fwd_hit_a  = hit_v[0];
  assign bus.fwd_hit_b  = hit_v[1];
  assign bus.fwd_hit_c  = hit_v[2];
  assign bus.fwd_pend_a = pend_v[0];
  assign bus.fwd_pend_b = pend_v[1];
  assign bus.fwd_pend_c = pend_v[2];
  assign bus.fwd_data_a = data_v[0];
  assign bus.fwd_data_b = data_v[1];
  assign bus.fwd_data_c = data_v[2];
endmodule

// File: tb/tb_spu_wb_pipe.sv
// Bench for spu_wb_pipe: writebacks scored against a queue filled at issue,
// forwarding/occupancy checked against per-scenario expected windows.
module tb_spu_wb_pipe;
  localparam int DEPTH = 7;
  localparam int DW    = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spu_wb_pipe_if #(.DEPTH(DEPTH), .DATA_WD(DW)) bus ();
  spu_wb_pipe #(.DEPTH(DEPTH), .DATA_WD(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int            due;
    logic [6:0]    addr;
    logic [DW-1:0] data;
  } wb_t;
  wb_t sb[$];

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Writeback scoreboard
  always @(negedge clk) begin
    wb_t e;
    if (!rst) begin
      if (bus.wb_en === 1'b1) begin
        if (sb.size() == 0) chk("wb_unexpected", DW'(1), DW'(0));
        else begin
          e = sb.pop_front();
          chk("wb_cyc",  DW'(cyc), DW'(e.due));
          chk("wb_addr", DW'(bus.wb_addr), DW'(e.addr));
          chk("wb_data", bus.wb_data, e.data);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("wb_missing", DW'(0), DW'(1));
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic issue(input logic [6:0] a, input logic [DW-1:0] d, input logic [3:0] l);
    wb_t e;
    bus.in_valid   = 1'b1;
    bus.in_rt_addr = a;
    bus.in_data    = d;
    bus.in_lat     = l;
    e.due  = cyc + DEPTH;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drop_inflight();
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
  endtask

  initial begin
    logic [DW-1:0] a5, d;
    logic          e_hit, e_pend;
    int            e_occ;
    a5 = {16{8'hA5}};

    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_rt_addr = 7'd5; bus.in_data = '1; bus.in_lat = 4'd1;
    bus.flush = 1'b0;
    bus.fwd_addr_a = 7'd5; bus.fwd_addr_b = 7'd5; bus.fwd_addr_c = 7'd5;

    // Reset held two cycles while an input is presented
    repeat (2) begin
      @(posedge clk); #2;
      chk("rst_wb_en",   DW'(bus.wb_en), DW'(0));
      chk("rst_wb_addr", DW'(bus.wb_addr), DW'(0));
      chk("rst_wb_data", bus.wb_data, DW'(0));
      chk("rst_hit_a",   DW'(bus.fwd_hit_a), DW'(0));
      chk("rst_hit_b",   DW'(bus.fwd_hit_b), DW'(0));
      chk("rst_pend_a",  DW'(bus.fwd_pend_a), DW'(0));
      chk("rst_data_a",  bus.fwd_data_a, DW'(0));
      chk("rst_occ",     DW'(bus.occupancy), DW'(0));
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // Single result, lat 2
    tick(); issue(7'd5, a5, 4'd2); #1;
    chk("t1_c0_hit",  DW'(bus.fwd_hit_a), DW'(0));
    chk("t1_c0_pend", DW'(bus.fwd_pend_a), DW'(0));
    for (int c = 1; c <= 8; c++) begin
      tick(); #1;
      e_hit = (c >= 2 && c <= 7);
      chk("t1_pend",  DW'(bus.fwd_pend_a), DW'(c == 1));
      chk("t1_hit",   DW'(bus.fwd_hit_a), DW'(e_hit));
      chk("t1_data",  bus.fwd_data_a, e_hit ? a5 : DW'(0));
      chk("t1_occ",   DW'(bus.occupancy), DW'(c <= 7));
      chk("t1_wb_en", DW'(bus.wb_en), DW'(c == 7));
    end

    // Youngest match wins
    bus.fwd_addr_a = 7'd9; bus.fwd_addr_b = 7'd9; bus.fwd_addr_c = 7'd5;
    tick(); issue(7'd9, DW'(1), 4'd1); #1;
    chk("t2_c0_hit", DW'(bus.fwd_hit_a), DW'(0));
    tick(); issue(7'd9, DW'(2), 4'd4); #1;
    chk("t2_c1_hit",  DW'(bus.fwd_hit_a), DW'(1));
    chk("t2_c1_data", bus.fwd_data_a, DW'(1));
    for (int c = 2; c <= 9; c++) begin
      tick(); #1;
      e_pend = (c <= 4);
      e_hit  = (c >= 5 && c <= 8);
      chk("t2_pend_a", DW'(bus.fwd_pend_a), DW'(e_pend));
      chk("t2_hit_a",  DW'(bus.fwd_hit_a), DW'(e_hit));
      chk("t2_data_a", bus.fwd_data_a, e_hit ? DW'(2) : DW'(0));
      chk("t2_hit_b",  DW'(bus.fwd_hit_b), DW'(e_hit));
      chk("t2_pend_b", DW'(bus.fwd_pend_b), DW'(e_pend));
      chk("t2_hit_c",  DW'(bus.fwd_hit_c), DW'(0));
      chk("t2_pend_c", DW'(bus.fwd_pend_c), DW'(0));
    end

    // Back-to-back stream of 10
    bus.fwd_addr_a = 7'h7f;
    for (int c = 0; c <= 17; c++) begin
      tick();
      if (c < 10) issue(7'(c), {$urandom, $urandom, $urandom, $urandom}, 4'd3);
      #1;
      e_occ = 0;
      for (int i = 0; i < 10; i++) if (c - i >= 1 && c - i <= DEPTH) e_occ++;
      chk("t3_occ",   DW'(bus.occupancy), DW'(e_occ));
      chk("t3_wb_en", DW'(bus.wb_en), DW'(c >= 7 && c <= 16));
    end

    // Flush with concurrent issue
    bus.fwd_addr_a = 7'd20;
    d = {$urandom, $urandom, $urandom, $urandom};
    tick(); issue(7'd20, d, 4'd1);
    tick(); issue(7'd21, DW'(21), 4'd1);
    tick(); issue(7'd22, DW'(22), 4'd1);
    tick();
    tick(); issue(7'd23, DW'(23), 4'd1); bus.flush = 1'b1; drop_inflight(); #1;
    chk("t4_pre_occ",  DW'(bus.occupancy), DW'(3));
    chk("t4_pre_hit",  DW'(bus.fwd_hit_a), DW'(1));
    chk("t4_pre_data", bus.fwd_data_a, d);
    tick(); #1;
    chk("t4_post_occ", DW'(bus.occupancy), DW'(0));
    chk("t4_post_hit", DW'(bus.fwd_hit_a), DW'(0));
    repeat (10) tick();

    // Latency clamp: 0 -> 1, 15 -> DEPTH
    bus.fwd_addr_a = 7'd30;
    d = {$urandom, $urandom, $urandom, $urandom};
    tick(); issue(7'd30, d, 4'd0); #1;
    chk("t5_l0_c0_hit", DW'(bus.fwd_hit_a), DW'(0));
    tick(); #1;
    chk("t5_l0_hit",  DW'(bus.fwd_hit_a), DW'(1));
    chk("t5_l0_data", bus.fwd_data_a, d);
    repeat (8) tick();
    bus.fwd_addr_a = 7'd31;
    d = {$urandom, $urandom, $urandom, $urandom};
    tick(); issue(7'd31, d, 4'd15);
    for (int c = 1; c <= 8; c++) begin
      tick(); #1;
      chk("t5_l15_pend", DW'(bus.fwd_pend_a), DW'(c <= 6));
      chk("t5_l15_hit",  DW'(bus.fwd_hit_a), DW'(c == 7));
      chk("t5_l15_data", bus.fwd_data_a, (c == 7) ? d : DW'(0));
    end

    // Reset mid-operation discards in-flight entries
    bus.fwd_addr_a = 7'd40;
    tick(); issue(7'd40, DW'(40), 4'd1);
    tick(); issue(7'd41, DW'(41), 4'd1);
    tick(); rst = 1'b1; drop_inflight(); #1;
    chk("t6_pre_occ", DW'(bus.occupancy), DW'(2));
    tick(); rst = 1'b0; #1;
    chk("t6_post_occ", DW'(bus.occupancy), DW'(0));
    chk("t6_post_hit", DW'(bus.fwd_hit_a), DW'(0));
    chk("t6_post_wb",  DW'(bus.wb_en), DW'(0));
    repeat (10) tick();

    repeat (DEPTH + 2) tick();
    chk("sb_drained", DW'(sb.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
